md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the 5-stage MIPS pipeline.
- Sits beside the E-stage ALU. It accepts mult/multu/div/divu/mthi/mtlo commands, models the fixed execution latency with a down-counter, and commits HI/LO on completion.
- It generates the stall request that holds D/E while any HI/LO consumer or producer would collide with an operation in flight.
- HI/LO outputs feed the E-stage result mux for mfhi/mflo, and from there the normal M/W writeback path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  E-stage command valid this cycle
- md_op  in  3  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  in  32  rs operand (E stage, already forwarded)
- B  in  32  rt operand (E stage, already forwarded)
- md_use_D  in  1  instruction in D is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  out  1  operation in flight
- stall  out  1  pipeline stall request to hazard unit
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset values: busy=0, HI=0, LO=0, internal counter=0, latched operands=0, latched op=none. stall=0 follows from busy=0 and start=0.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter = remaining cycles).
- Accept rule: a command is accepted only when start=1 and state is IDLE.
  - start=1 while in RUN is ignored: no operand latch, no HI/LO change, counter undisturbed. The bench flags this as a protocol error. The hazard unit prevents it.
- mult/multu/div/divu accepted at cycle t:
  - A, B and op are latched at the edge ending t.
  - busy=1 during cycles t+1 .. t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - Counter loads N-1 and decrements each RUN cycle. RUN exits to IDLE when the counter is 0.
  - HI/LO are written at the edge ending cycle t+N. New values are visible from cycle t+N+1, the first cycle with busy=0.
- Result rules:
  - mult: signed 64-bit product of latched A and B; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product of latched A and B; HI=[63:32], LO=[31:0].
  - div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - divu: unsigned quotient in LO, unsigned remainder in HI.
  - Arithmetic is computed from the latched operands, not from live A/B.
- Boundary cases:
  - Divide by zero (latched B=0, div or divu): the full busy period still elapses, and HI/LO keep their prior values.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- mthi/mtlo accepted at cycle t:
  - HI (or LO) = A at the edge ending t, with no RUN state and busy stays 0.
  - Only the targeted register changes.
- stall = md_use_D & (busy | (start & md_op in {1,2,3,4})).
  - Combinational; asserted in the accept cycle itself so a dependent mfhi/mflo in D never reads stale HI/LO.
- Completion edge with a new start: in the busy=0 cycle after completion a new start is accepted normally. Back-to-back operations therefore have exactly one idle cycle between busy periods.
- Reset asserted mid-operation (any RUN cycle):
  - The operation is abandoned at that edge, with no HI/LO commit.
  - All state returns to reset values.
  - A start in the cycle after reset deasserts is accepted.
- Reset and start in the same cycle: reset wins, and the command is discarded.

Test Plan:
- Reset mid-run, start mult: reset 2 cycles; check HI=LO=0, busy=0. Then start mult A=3 B=4; assert reset on the 3rd busy cycle, release. Required: busy=0 next cycle, HI=LO=0, no later commit.
- Signed mult: mult A=0xFFFFFFFE (-2), B=5 at cycle t. Required: busy high cycles t+1..t+5; HI=0xFFFFFFFF, LO=0xFFFFFFF6 from cycle t+6; HI/LO unchanged before that.
- Operand isolation, multu: multu A=0xFFFFFFFF B=0xFFFFFFFF, then change A/B to 0 after the start cycle. Required: HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- Signed div and divide by zero:
  - div A=0xFFFFFFF9 (-7), B=2. Required: 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then divu with B=0. Required: 10 busy cycles; HI/LO unchanged.
- mthi/mtlo and ignored start: mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles. Required: busy never set; HI=0x12345678 and LO=0x9ABCDEF0 visible the cycle after each write. Then start mtlo while a mult is running. Required: ignored.
- Stall generation: start div with md_use_D=1. Required: stall=1 in the accept cycle and all 10 busy cycles, stall=0 the cycle busy falls. With md_use_D=0 throughout, stall stays 0.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage: fixed-latency busy window,
// HI/LO commit on completion, and the D/E stall request for HI/LO users.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } md_op_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      r_state, w_next;
    md_op_t      r_op;
    logic [3:0]  r_cnt;
    logic [31:0] r_a, r_b, r_hi, r_lo;

    logic        w_is_md, w_is_mult, w_accept, w_load, w_done, w_commit;
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_mag_a, w_mag_b, w_den_s, w_den_u;
    logic [31:0] w_sq_u, w_sr_u, w_sq, w_sr, w_uq, w_ur;
    logic [31:0] w_res_hi, w_res_lo;

    always_comb begin
        w_is_mult = (md_op == OP_MULT) || (md_op == OP_MULTU);
        w_is_md   = w_is_mult || (md_op == OP_DIV) || (md_op == OP_DIVU);
        w_next    = r_state;
        w_accept  = 1'b0;
        w_load    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_is_md) begin
                        w_load = 1'b1;
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd0) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        busy  = (r_state == S_RUN);
        stall = md_use_D & (busy | (start & w_is_md));
    end

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_prod_u = {32'd0, r_a} * {32'd0, r_b};
        w_mag_a  = r_a[31] ? (32'd0 - r_a) : r_a;
        w_mag_b  = r_b[31] ? (32'd0 - r_b) : r_b;
        w_den_s  = (w_mag_b == '0) ? 32'd1 : w_mag_b;
        w_den_u  = (r_b == '0) ? 32'd1 : r_b;
        w_sq_u   = w_mag_a / w_den_s;
        w_sr_u   = w_mag_a % w_den_s;
        w_sq     = (r_a[31] ^ r_b[31]) ? (32'd0 - w_sq_u) : w_sq_u;
        w_sr     = r_a[31] ? (32'd0 - w_sr_u) : w_sr_u;
        w_uq     = r_a / w_den_u;
        w_ur     = r_a % w_den_u;

        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_commit = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_commit = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_commit = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_commit = (r_b != '0);
            end
            OP_DIVU: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
                w_commit = (r_b != '0);
            end
            default: w_commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= OP_NONE;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_load) begin
                r_a   <= A;
                r_b   <= B;
                r_op  <= md_op_t'(md_op);
                r_cnt <= w_is_mult ? MULT_LOAD : DIV_LOAD;
            end else if (busy && !w_done) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_accept && (md_op == OP_MTHI)) r_hi <= A;
            if (w_accept && (md_op == OP_MTLO)) r_lo <= A;
            if (w_done && w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus queues HI/LO updates with their
// visibility cycle; a negedge monitor checks busy/stall/HI/LO every cycle.
module tb_md_unit_ctrl;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        md_use_D = 1'b0;
    logic        busy, stall;
    logic [31:0] HI, LO;

    md_unit_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .md_use_D(md_use_D),
        .busy(busy), .stall(stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          clr;
        bit          wh;
        bit          wl;
        logic [31:0] hi;
        logic [31:0] lo;
    } upd_t;

    upd_t        sbq[$];
    upd_t        mu;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    int          b_start = 0;
    int          b_end = -1;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;
    logic        eb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Architectural reference: results straight from the instruction definitions.
    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output bit wh, output bit wl,
                                       output logic [31:0] hi, output logic [31:0] lo);
        longint          sp, sq, sr;
        longint unsigned up, ub;
        wh = 0; wl = 0; hi = '0; lo = '0;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32]; lo = sp[31:0]; wh = 1; wl = 1;
            end
            3'd2: begin
                up = {32'd0, a}; ub = {32'd0, b}; up = up * ub;
                hi = up[63:32]; lo = up[31:0]; wh = 1; wl = 1;
            end
            3'd3: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                hi = sr[31:0]; lo = sq[31:0]; wh = 1; wl = 1;
            end
            3'd4: if (b != 0) begin
                hi = a % b; lo = a / b; wh = 1; wl = 1;
            end
            3'd5: begin hi = a; wh = 1; end
            3'd6: begin lo = a; wl = 1; end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                mu = sbq.pop_front();
                if (mu.clr) begin
                    cur_hi = '0;
                    cur_lo = '0;
                end else begin
                    if (mu.wh) cur_hi = mu.hi;
                    if (mu.wl) cur_lo = mu.lo;
                end
            end
            eb = (cyc >= b_start) && (cyc <= b_end);
            chk("busy", busy, eb);
            chk("stall", stall, md_use_D & (eb | (start & (md_op >= 3'd1) & (md_op <= 3'd4))));
            chk("HI", HI, cur_hi);
            chk("LO", LO, cur_lo);
        end
    end

    // Drive one cycle of inputs (called just after a rising edge) and update the model.
    task automatic step(input bit st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit use_d, input bit rst);
        int          t;
        int          n;
        bit          wh, wl;
        logic [31:0] h, l;
        upd_t        u;
        t = cyc;
        reset = rst; start = st; md_op = op; A = a; B = b; md_use_D = use_d;
        if (rst) begin
            while (sbq.size() > 0 && sbq[$].due > t) void'(sbq.pop_back());
            if (b_end > t) b_end = t;
            u = '{due: t + 1, clr: 1'b1, wh: 1'b0, wl: 1'b0, hi: '0, lo: '0};
            sbq.push_back(u);
        end else if (st && !((t >= b_start) && (t <= b_end))) begin
            if (op >= 3'd1 && op <= 3'd6) begin
                ref_result(op, a, b, wh, wl, h, l);
                if (op <= 3'd4) begin
                    n = (op <= 3'd2) ? NM : ND;
                    b_start = t + 1;
                    b_end = t + n;
                    u = '{due: t + n + 1, clr: 1'b0, wh: wh, wl: wl, hi: h, lo: l};
                end else begin
                    u = '{due: t + 1, clr: 1'b0, wh: wh, wl: wl, hi: h, lo: l};
                end
                sbq.push_back(u);
            end
        end else if (st && op != 3'd0 && op != 3'd7) begin
            $display("note: cyc=%0d start ignored while busy (protocol error)", t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit use_d);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom, use_d, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          rr, ss, uu;
        int          r, w;
        logic [2:0]  op;
        @(posedge clk);
        #1;
        step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);

        // mult abandoned by reset on its third busy cycle
        step(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        idle(8, 1'b0);

        step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd5, 1'b0, 1'b0);
        idle(7, 1'b0);

        step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);

        step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(11, 1'b0);
        step(1'b1, 3'd4, 32'd123, 32'd0, 1'b0, 1'b0);
        idle(11, 1'b0);

        step(1'b1, 3'd5, 32'h1234_5678, '0, 1'b0, 1'b0);
        step(1'b1, 3'd6, 32'h9ABC_DEF0, '0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd7, 32'd9, 1'b0, 1'b0);
        step(1'b1, 3'd6, 32'hDEAD_BEEF, '0, 1'b0, 1'b0);
        idle(6, 1'b0);

        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        idle(11, 1'b1);
        step(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
        idle(6, 1'b0);

        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(11, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            rr = (r < 3);
            ss = rr ? 1'($urandom_range(0, 1)) : (r < 55);
            op = 3'($urandom_range(0, 7));
            uu = 1'($urandom_range(0, 1));
            step(ss, op, pick(), pick(), uu, rr);
        end

        w = 0;
        while (sbq.size() > 0 && w < 40) begin
            idle(1, 1'b0);
            w++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        idle(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
